// File: rtl/fft_bsram_loader_if.sv
// Sample stream interface feeding fft_bsram_loader.
//   in_valid  source -> loader  sample valid
//   in_ready  loader -> source  loader accepts the sample this cycle
//   in_data   source -> loader  sample {re[31:16], im[15:0]}
//   in_last   source -> loader  final sample of the frame
// Modports: master = sample source, slave = loader.
interface fft_bsram_loader_if #(
  parameter int unsigned DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/fft_bsram_loader.sv
// Writer side of the fft0/fft1 BSRAM pair used by fft1024. Accepts a frame of complex
// samples, zero-pads a short frame up to N samples, fills both single-port RAMs (each
// holds N/2 words), then hands them to fft1024 by raising sel and pulsing fft_start.
// A finish from fft1024 returns the RAMs to the loader and pulses done.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   arm                    1-cycle pulse, starts a new load when idle
//   src (slave modport)    sample stream: in_valid/in_ready/in_data/in_last
//   ce0/oce0/wre0/ad0/din0 fft0 BSRAM write port (loader side of the mux)
//   ce1/oce1/wre1/ad1/din1 fft1 BSRAM write port (loader side of the mux)
//   sel                    0 = loader owns the RAMs, 1 = fft1024 owns them
//   fft_start              1-cycle start pulse to fft1024
//   fft_finish             completion from fft1024
//   done                   1-cycle pulse after fft1024 finishes
//   busy                   high in every state except idle
//
// Build option: define FFT_LOADER_BITREV_EN to bit-reverse the write index (data and
// padding) for an in-place DIT fft1024 that expects bit-reversed input.
// N must be a power of two so the sample counter wraps to 0 on entering start.
module fft_bsram_loader #(
  parameter int unsigned N  = 1024,
  parameter int unsigned AW = 11,
  parameter int unsigned DW = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                arm,
  fft_bsram_loader_if.slave   src,
  output logic                ce0,
  output logic                oce0,
  output logic                wre0,
  output logic [AW-1:0]       ad0,
  output logic [DW-1:0]       din0,
  output logic                ce1,
  output logic                oce1,
  output logic                wre1,
  output logic [AW-1:0]       ad1,
  output logic [DW-1:0]       din1,
  output logic                sel,
  output logic                fft_start,
  input  logic                fft_finish,
  output logic                done,
  output logic                busy
);

  localparam int unsigned KW = $clog2(N);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StPad,
    StStart,
    StRun
  } state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] cnt_q, cnt_d;
  logic          sel_q, sel_d;
  logic          start_q, start_d;
  logic          done_q, done_d;

  logic          accept;
  logic          last_idx;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic [KW-1:0] wr_idx;
  logic          wr_bank;
  logic [AW-1:0] wr_addr;

  assign src.in_ready = (state_q == StLoad);
  assign accept       = src.in_valid && (state_q == StLoad);
  assign last_idx     = (cnt_q == KW'(N - 1));

  assign busy      = (state_q != StIdle);
  assign sel       = sel_q;
  assign fft_start = start_q;
  assign done      = done_q;

`ifdef FFT_LOADER_BITREV_EN
  always_comb begin
    wr_idx = '0;
    for (int i = 0; i < KW; i++) begin
      wr_idx[i] = cnt_q[KW-1-i];
    end
  end
`else
  assign wr_idx = cnt_q;
`endif

  // Top index bit picks the bank; the rest is the word address within it.
  assign wr_bank = wr_idx[KW-1];
  assign wr_addr = AW'(wr_idx[KW-2:0]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    start_d = 1'b0;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    unique case (state_q)
      StIdle: begin
        if (arm) state_d = StLoad;
      end
      StLoad: begin
        if (accept) begin
          wr_en   = 1'b1;
          wr_data = src.in_data;
          cnt_d   = cnt_q + KW'(1);
          // A full frame ends the load regardless of in_last.
          if (last_idx) begin
            state_d = StStart;
          end else if (src.in_last) begin
            state_d = StPad;
          end
        end
      end
      StPad: begin
        wr_en = 1'b1;
        cnt_d = cnt_q + KW'(1);
        if (last_idx) state_d = StStart;
      end
      StStart: begin
        // The final write strobe is on the RAM pins during this cycle; the
        // handover becomes visible on the next one.
        sel_d   = 1'b1;
        start_d = 1'b1;
        state_d = StRun;
      end
      StRun: begin
        if (fft_finish) begin
          sel_d   = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      start_q <= start_d;
      done_q  <= done_d;
    end
  end

  // Registered RAM write port: strobes last exactly one cycle per write and only on
  // the selected bank. Address/data of an idle bank simply hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce0  <= 1'b0;
      oce0 <= 1'b0;
      wre0 <= 1'b0;
      ad0  <= '0;
      din0 <= '0;
      ce1  <= 1'b0;
      oce1 <= 1'b0;
      wre1 <= 1'b0;
      ad1  <= '0;
      din1 <= '0;
    end else begin
      ce0  <= 1'b0;
      oce0 <= 1'b0;
      wre0 <= 1'b0;
      ce1  <= 1'b0;
      oce1 <= 1'b0;
      wre1 <= 1'b0;
      if (wr_en) begin
        if (!wr_bank) begin
          ce0  <= 1'b1;
          oce0 <= 1'b1;
          wre0 <= 1'b1;
          ad0  <= wr_addr;
          din0 <= wr_data;
        end else begin
          ce1  <= 1'b1;
          oce1 <= 1'b1;
          wre1 <= 1'b1;
          ad1  <= wr_addr;
          din1 <= wr_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_bsram_loader.sv
// Directed bench for fft_bsram_loader: models both BSRAM banks from the write strobes
// and compares their contents, handover timing and control pulses against
// hand-derived expectations.
module tb_fft_bsram_loader;

  localparam int N    = 1024;
  localparam int HALF = 512;
  localparam int AW   = 11;
  localparam int DW   = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arm = 1'b0;
  logic          fft_finish = 1'b0;
  logic          ce0, oce0, wre0, ce1, oce1, wre1;
  logic [AW-1:0] ad0, ad1;
  logic [DW-1:0] din0, din1;
  logic          sel, fft_start, done, busy;

  fft_bsram_loader_if #(.DW(DW)) src_if ();

  fft_bsram_loader #(.N(N), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arm        (arm),
    .src        (src_if),
    .ce0        (ce0),
    .oce0       (oce0),
    .wre0       (wre0),
    .ad0        (ad0),
    .din0       (din0),
    .ce1        (ce1),
    .oce1       (oce1),
    .wre1       (wre1),
    .ad1        (ad1),
    .din1       (din1),
    .sel        (sel),
    .fft_start  (fft_start),
    .fft_finish (fft_finish),
    .done       (done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // ---------------- RAM model / write monitor ----------------
  logic [DW-1:0] mem0 [HALF];
  logic [DW-1:0] mem1 [HALF];
  bit            seen0 [HALF];
  bit            seen1 [HALF];
  int            wr_cnt, dup_cnt, strobe_err, both_err, addr_err;
  int            cyc, last_wr_cyc, last_wr_phys, start_cyc, start_cnt;
  logic          sel_at_start, sel_at_last_wr;
  logic          clr = 1'b0;

  initial begin
    wr_cnt = 0; dup_cnt = 0; strobe_err = 0; both_err = 0; addr_err = 0;
    cyc = 0; last_wr_cyc = 0; last_wr_phys = 0; start_cyc = 0; start_cnt = 0;
    sel_at_start = 1'b0; sel_at_last_wr = 1'b0;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (clr) begin
      for (int a = 0; a < HALF; a++) begin
        mem0[a]  <= 32'hDEAD_BEEF;
        mem1[a]  <= 32'hDEAD_BEEF;
        seen0[a] <= 1'b0;
        seen1[a] <= 1'b0;
      end
      wr_cnt <= 0; dup_cnt <= 0; strobe_err <= 0; both_err <= 0; addr_err <= 0;
    end else begin
      if (ce0 != wre0 || ce0 != oce0 || ce1 != wre1 || ce1 != oce1)
        strobe_err <= strobe_err + 1;
      if (ce0 && ce1) both_err <= both_err + 1;
      if (ce0 && wre0) begin
        if (ad0[AW-1:9] != 2'b00) addr_err <= addr_err + 1;
        if (seen0[ad0[8:0]]) dup_cnt <= dup_cnt + 1;
        mem0[ad0[8:0]]  <= din0;
        seen0[ad0[8:0]] <= 1'b1;
        wr_cnt          <= wr_cnt + 1;
        last_wr_cyc     <= cyc;
        last_wr_phys    <= int'(ad0[8:0]);
        sel_at_last_wr  <= sel;
      end
      if (ce1 && wre1) begin
        if (ad1[AW-1:9] != 2'b00) addr_err <= addr_err + 1;
        if (seen1[ad1[8:0]]) dup_cnt <= dup_cnt + 1;
        mem1[ad1[8:0]]  <= din1;
        seen1[ad1[8:0]] <= 1'b1;
        wr_cnt          <= wr_cnt + 1;
        last_wr_cyc     <= cyc;
        last_wr_phys    <= HALF + int'(ad1[8:0]);
        sel_at_last_wr  <= sel;
      end
    end
    if (fft_start) begin
      start_cnt    <= start_cnt + 1;
      start_cyc    <= cyc;
      sel_at_start <= sel;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int rev10(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 10; i++) if (v[i]) r |= (1 << (9 - i));
    return r;
  endfunction

  // Sample index stored at physical word p (bank*512 + addr).
  function automatic int phys2k(input int p);
`ifdef FFT_LOADER_BITREV_EN
    return rev10(p);
`else
    return p;
`endif
  endfunction

  task automatic verify_mem(input string tag, input int last_k);
    int errs;
    int k;
    logic [31:0] got, exp;
    errs = 0;
    for (int p = 0; p < N; p++) begin
      k   = phys2k(p);
      exp = (k <= last_k) ? 32'(k) : 32'h0;
      got = (p < HALF) ? mem0[p] : mem1[p - HALF];
      if (got !== exp) errs++;
    end
    check(tag, 32'(errs), 32'h0);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic clear_model();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic pulse_arm();
    @(negedge clk); arm = 1'b1;
    @(negedge clk); arm = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last, output bit ok);
    @(negedge clk);
    src_if.in_valid = 1'b1;
    src_if.in_data  = d;
    src_if.in_last  = last;
    for (int i = 0; i < 8 && !src_if.in_ready; i++) @(negedge clk);
    ok = src_if.in_ready;
    @(posedge clk);
    #1;
    src_if.in_valid = 1'b0;
    src_if.in_last  = 1'b0;
  endtask

  task automatic stream(input int first, input int count, input int last_k, input bit gaps,
                        output int errs);
    bit ok;
    errs = 0;
    for (int k = first; k < first + count; k++) begin
      send_beat(32'(k), k == last_k, ok);
      if (!ok) errs++;
      if (gaps) @(negedge clk);
    end
  endtask

  // Waits for fft_start, counting cycles where in_ready was high meanwhile.
  task automatic wait_start(output bit ok, output int rdy_hi);
    ok = 1'b0;
    rdy_hi = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (fft_start) begin
        ok = 1'b1;
        break;
      end
      if (src_if.in_ready) rdy_hi++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_handover(input string tag);
    check({tag, "_start_lat"}, 32'(start_cyc - last_wr_cyc), 32'd1);
    check({tag, "_sel_at_start"}, 32'(sel_at_start), 32'd1);
    check({tag, "_sel_at_last_wr"}, 32'(sel_at_last_wr), 32'd0);
    check({tag, "_last_wr_phys"}, 32'(last_wr_phys), 32'(N - 1));
    check({tag, "_start_one_cycle"}, 32'(fft_start), 32'd0);
    check({tag, "_wr_cnt"}, 32'(wr_cnt), 32'(N));
    check({tag, "_dup"}, 32'(dup_cnt), 32'd0);
    check({tag, "_strobe_err"}, 32'(strobe_err + both_err + addr_err), 32'd0);
  endtask

  task automatic finish_fft(input string tag, input int dly);
    repeat (dly) @(negedge clk);
    fft_finish = 1'b1;
    @(negedge clk);
    fft_finish = 1'b0;
    check({tag, "_done_sel_busy"}, {29'd0, done, sel, busy}, 32'b100);
    @(negedge clk);
    check({tag, "_done_pulse"}, {30'd0, done, busy}, 32'b00);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    int errs, rdy_hi, starts_before, wr_before;

    src_if.in_valid = 1'b0;
    src_if.in_data  = '0;
    src_if.in_last  = 1'b0;

    // Reset state.
    #12;
    check("rst_ctrl", {27'd0, sel, src_if.in_ready, fft_start, done, busy}, 32'd0);
    check("rst_strobes", {26'd0, ce0, oce0, wre0, ce1, oce1, wre1}, 32'd0);
    check("rst_ad", {ad1, ad0}, 32'd0);
    check("rst_din0", din0, 32'd0);
    check("rst_din1", din1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // fft_finish while idle is ignored.
    @(negedge clk); fft_finish = 1'b1;
    @(negedge clk); fft_finish = 1'b0;
    check("idle_finish_ignored", {30'd0, done, busy}, 32'd0);

    // 1: full frame, data = k, no in_last.
    clear_model();
    pulse_arm();
    check("t1_armed", {30'd0, busy, src_if.in_ready}, 32'b11);
    starts_before = start_cnt;
    stream(0, N, -1, 1'b0, errs);
    check("t1_stall", 32'(errs), 32'd0);
    wait_start(ok, rdy_hi);
    check("t1_start_seen", 32'(ok), 32'd1);
    check("t1_ready_after_load", 32'(rdy_hi), 32'd0);
    check("t1_start_count", 32'(start_cnt - starts_before), 32'd1);
    check("t1_sel_run", {30'd0, sel, busy}, 32'b11);
    check_handover("t1");
    verify_mem("t1_mem", N - 1);
`ifdef FFT_LOADER_BITREV_EN
    check("t6_k1", mem1[0], 32'd1);
    check("t6_k2", mem0[256], 32'd2);
`else
    check("t1_fft0_5", mem0[5], 32'd5);
    check("t1_fft1_0", mem1[0], 32'd512);
    check("t1_fft1_511", mem1[511], 32'd1023);
`endif

    // 4: finish 20 cycles after start; arm in RUN tested below.
    finish_fft("t4", 20);

    // 2: short frame, in_last on k=99, padding follows.
    clear_model();
    pulse_arm();
    stream(0, 100, 99, 1'b0, errs);
    check("t2_stall", 32'(errs), 32'd0);
    wait_start(ok, rdy_hi);
    check("t2_start_seen", 32'(ok), 32'd1);
    check("t2_ready_in_pad", 32'(rdy_hi), 32'd0);
    check_handover("t2");
    verify_mem("t2_mem", 99);
    finish_fft("t2", 3);

    // 3: in_valid toggled every cycle, in_last on the final beat.
    clear_model();
    pulse_arm();
    stream(0, N, N - 1, 1'b1, errs);
    check("t3_stall", 32'(errs), 32'd0);
    wait_start(ok, rdy_hi);
    check("t3_start_seen", 32'(ok), 32'd1);
    check_handover("t3");
    verify_mem("t3_mem", N - 1);
    finish_fft("t3", 5);

    // 5: reset mid-load, then reload and poke arm/in_valid during RUN.
    clear_model();
    pulse_arm();
    stream(0, 300, -1, 1'b0, errs);
    starts_before = start_cnt;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_rst_ctrl", {27'd0, sel, src_if.in_ready, fft_start, done, busy}, 32'd0);
    check("t5_rst_strobes", {26'd0, ce0, oce0, wre0, ce1, oce1, wre1}, 32'd0);
    check("t5_rst_ad", {ad1, ad0}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_no_start", 32'(start_cnt - starts_before), 32'd0);
    check("t5_idle", {30'd0, busy, sel}, 32'd0);

    clear_model();
    pulse_arm();
    stream(0, N, -1, 1'b0, errs);
    check("t5_stall", 32'(errs), 32'd0);
    wait_start(ok, rdy_hi);
    check("t5_start_seen", 32'(ok), 32'd1);
    wr_before = wr_cnt;
    @(negedge clk);
    arm = 1'b1;
    src_if.in_valid = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    repeat (4) @(negedge clk);
    src_if.in_valid = 1'b0;
    check("t5_arm_in_run", {29'd0, busy, sel, src_if.in_ready}, 32'b110);
    check("t5_no_write_in_run", 32'(wr_cnt - wr_before), 32'd0);
    verify_mem("t5_mem", N - 1);
    finish_fft("t5", 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
